// File: rtl/tank_level_sense_pkg.sv
// Shared encodings for the tank level sensor: watchdog states, fault bit
// positions and the legal thermometer codes of the three probes.
package tank_level_sense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_TIMEOUT = 2'd2
    } fill_state_e;

    localparam int FC_INVALID = 0;
    localparam int FC_TIMEOUT = 1;

    localparam int TIMER_W = 16;

    localparam logic [2:0] LVL_CODE0 = 3'b000;
    localparam logic [2:0] LVL_CODE1 = 3'b001;
    localparam logic [2:0] LVL_CODE2 = 3'b011;
    localparam logic [2:0] LVL_CODE3 = 3'b111;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == LVL_CODE0) || (code == LVL_CODE1) ||
               (code == LVL_CODE2) || (code == LVL_CODE3);
    endfunction

    function automatic logic [1:0] code_level(input logic [2:0] code);
        return {1'b0, code[0]} + {1'b0, code[1]} + {1'b0, code[2]};
    endfunction

endpackage

// File: rtl/tank_level_sense_probe_debounce.sv
// One probe: 2-flop synchronizer then a stability counter; the output only
// follows the input after DEB_CYC consecutive disagreeing samples.
module probe_debounce #(
    parameter int DEB_CYC = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);
    localparam int CW = $clog2(DEB_CYC);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            deb <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tank_level_sense.sv
// Tank level sensor: debounced probes validated into a thermometer level,
// plus a fill watchdog that flags a valve left open without level progress.
module tank_level_sense
    import tank_level_sense_pkg::*;
#(
    parameter int DEB_CYC      = 8,
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Sw0,
    input  logic       Sw1,
    input  logic       Sw2,
    input  logic       Ve,
    input  logic       Clr,
    output logic       Nv0,
    output logic       Nv1,
    output logic       Nv2,
    output logic       Fault,
    output logic [1:0] FaultCode
);
    logic [2:0]         sw_raw;
    logic [2:0]         deb;
    logic [2:0]         nv;
    logic [1:0]         lvl, lvl_prev;
    logic [TIMER_W-1:0] timer;
    fill_state_e        state;
    logic [1:0]         fc_next;
    logic               set_inv, set_to, lvl_up;

    assign sw_raw = {Sw2, Sw1, Sw0};

    for (genvar i = 0; i < 3; i++) begin : g_probe
        probe_debounce #(.DEB_CYC(DEB_CYC)) u_probe (
            .clk  (clk),
            .reset(reset),
            .raw  (sw_raw[i]),
            .deb  (deb[i])
        );
    end

    assign lvl    = code_level(nv);
    assign lvl_up = lvl > lvl_prev;

    always_comb begin
        set_inv = !code_valid(deb);
        set_to  = (state == ST_FILLING) && Ve && (lvl != 2'd3) && !lvl_up &&
                  (timer == TIMER_W'(FILL_TIMEOUT - 1));
        // Sticky flags; a fresh set condition beats a simultaneous clear.
        fc_next                = FaultCode & {2{~Clr}};
        fc_next[FC_INVALID]    = fc_next[FC_INVALID] | set_inv;
        fc_next[FC_TIMEOUT]    = fc_next[FC_TIMEOUT] | set_to;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nv        <= LVL_CODE0;
            lvl_prev  <= 2'd0;
            state     <= ST_IDLE;
            timer     <= '0;
            FaultCode <= 2'b00;
            Fault     <= 1'b0;
        end else begin
            if (!set_inv) nv <= deb;
            lvl_prev  <= lvl;
            FaultCode <= fc_next;
            Fault     <= |fc_next;

            case (state)
                ST_IDLE: begin
                    if (Ve && lvl != 2'd3) begin
                        state <= ST_FILLING;
                        timer <= '0;
                    end
                end
                ST_FILLING: begin
                    if (!Ve || lvl == 2'd3) begin
                        state <= ST_IDLE;
                    end else if (lvl_up) begin
                        timer <= '0;
                    end else if (set_to) begin
                        state <= ST_TIMEOUT;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    if (!Ve) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Nv0 = nv[0];
    assign Nv1 = nv[1];
    assign Nv2 = nv[2];

endmodule
